conv_acc_ctrl: RTL and testbench



---
 rtl/conv_ctrl_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/conv_acc_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_conv_acc_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_ctrl_pkg.sv
// Shared types and arithmetic helpers for the convolution accumulate controller.
package conv_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Working width for the clamp helper; callers sign-extend into it.
  localparam int unsigned CALC_W = 32;

  // Optional ReLU followed by signed saturation to an out_w-bit range.
  function automatic logic signed [CALC_W-1:0] relu_sat(
      input logic signed [CALC_W-1:0] val,
      input logic                     relu_en,
      input int unsigned              out_w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    logic signed [CALC_W-1:0] r;
    hi = $signed((CALC_W'(1) << (out_w - 1)) - CALC_W'(1));
    lo = ~hi;
    r  = val;
    if (relu_en && (r < 0)) r = '0;
    if (r > hi)      r = hi;
    else if (r < lo) r = lo;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head-of-queue read port; data appears the cycle after push.
// Pop of an empty FIFO and push into a full FIFO without a pop are dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic [AW-1:0]    rd_next;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_next = ptr_inc(rd_ptr_q);
  assign rd_data = data_q;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_next : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    data_d   = data_q;
    // The head register is refilled from memory, or straight from the write port when it would otherwise run dry.
    if (do_pop) begin
      if (count_q > CW'(1)) data_d = mem_q[rd_next];
      else if (do_push)     data_d = push_data;
    end else if (empty && do_push) begin
      data_d = push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/conv_acc_ctrl.sv
// Plane sequencer for one mac: issues (pixel, group) fetches, accumulates results across groups,
// applies bias/shift/ReLU/saturation and buffers pixels; credits keep the output buffer from overflowing.
module conv_acc_ctrl
  import conv_ctrl_pkg::*;
#(
  parameter int unsigned INPUT_NUM = 9,
  parameter int unsigned GROUPS    = 4,
  parameter int unsigned WDP       = 9,
  parameter int unsigned WDP_OUT   = 17,
  parameter int unsigned WDP_BIAS  = 13,
  parameter int unsigned WDP_ACC   = 22,
  parameter int unsigned SHIFT     = 2,
  parameter int unsigned OUT_DEPTH = 4,
  parameter int unsigned PIX_W     = 16,
  localparam int unsigned GRP_W    = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [PIX_W-1:0]           cfg_pixels,
  input  logic signed [WDP_BIAS-1:0] cfg_bias,
  input  logic                       cfg_relu,
  output logic                       busy,
  output logic                       done,
  output logic                       fetch_en,
  output logic [PIX_W-1:0]           fetch_pix,
  output logic [GRP_W-1:0]           fetch_grp,
  input  logic                       mac_q_en,
  input  logic signed [WDP_OUT-1:0]  mac_q,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WDP-1:0]      out_data
);

  localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int unsigned SUM_W = WDP_ACC + 1;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);

  if ((GROUPS < 1) || (INPUT_NUM < 1)) begin : g_param_check
    $error("conv_acc_ctrl: GROUPS and INPUT_NUM must be at least 1");
  end

  state_e                     state_q, state_d;
  logic [PIX_W-1:0]           pixels_q, pixels_d;
  logic signed [WDP_BIAS-1:0] bias_q, bias_d;
  logic                       relu_q, relu_d;
  logic                       fetch_en_q, fetch_en_d;
  logic [PIX_W-1:0]           pix_q, pix_d;
  logic [GRP_W-1:0]           grp_q, grp_d;
  logic [CNT_W-1:0]           used_q, used_d;
  logic [GRP_W-1:0]           rg_q, rg_d;
  logic signed [WDP_ACC-1:0]  acc_q, acc_d;

  logic                       pop;
  logic                       fifo_empty;
  logic                       last_fetch;
  logic                       credit_ok;
  logic                       acc_en;
  logic                       res_push;
  logic signed [WDP_ACC-1:0]  acc_base;
  logic signed [WDP_ACC-1:0]  acc_sum;
  logic signed [SUM_W-1:0]    sum_full;
  logic signed [SUM_W-1:0]    shifted;
  logic signed [CALC_W-1:0]   clamped;
  logic [WDP-1:0]             res_val;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign fetch_en  = fetch_en_q;
  assign fetch_pix = pix_q;
  assign fetch_grp = grp_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // used_q counts buffered results plus pixels in flight; the push of a finished
  // pixel moves it between the two, so only a new pixel start or a pop changes it.
  assign used_d    = used_q + CNT_W'(fetch_en_q && (grp_q == '0)) - CNT_W'(pop);
  assign credit_ok = (used_d < CNT_W'(OUT_DEPTH));
  assign last_fetch = fetch_en_q && (pix_q == (pixels_q - PIX_W'(1))) && (grp_q == GRP_LAST);

  always_comb begin
    state_d    = state_q;
    pixels_d   = pixels_q;
    bias_d     = bias_q;
    relu_d     = relu_q;
    fetch_en_d = 1'b0;
    pix_d      = pix_q;
    grp_d      = grp_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pixels_d = cfg_pixels;
          bias_d   = cfg_bias;
          relu_d   = cfg_relu;
          pix_d    = '0;
          grp_d    = '0;
          // An empty plane still spends one cycle in DRAIN so done lands two cycles after start.
          if (cfg_pixels == '0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d    = ST_ISSUE;
            fetch_en_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (fetch_en_q) begin
          if (last_fetch) begin
            state_d = ST_DRAIN;
          end else if (grp_q == GRP_LAST) begin
            grp_d      = '0;
            pix_d      = pix_q + PIX_W'(1);
            fetch_en_d = credit_ok;
          end else begin
            grp_d      = grp_q + GRP_W'(1);
            fetch_en_d = 1'b1;
          end
        end else begin
          fetch_en_d = credit_ok;
        end
      end
      ST_DRAIN: begin
        if ((used_q == '0) && !out_valid) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign acc_en   = mac_q_en && busy;
  assign res_push = acc_en && (rg_q == GRP_LAST);
  assign acc_base = (rg_q == '0) ? '0 : acc_q;
  assign acc_sum  = acc_base + WDP_ACC'(mac_q);
  // Bias is pre-scaled so that the shift rounds the biased sum as a whole.
  assign sum_full = SUM_W'(acc_sum) + (SUM_W'(bias_q) <<< SHIFT);
  assign shifted  = sum_full >>> SHIFT;
  assign clamped  = relu_sat(CALC_W'(shifted), relu_q, WDP);
  assign res_val  = clamped[WDP-1:0];

  always_comb begin
    rg_d  = rg_q;
    acc_d = acc_q;
    if (acc_en) begin
      if (rg_q == GRP_LAST) begin
        rg_d = '0;
      end else begin
        rg_d  = rg_q + GRP_W'(1);
        acc_d = acc_sum;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      pixels_q   <= '0;
      bias_q     <= '0;
      relu_q     <= 1'b0;
      fetch_en_q <= 1'b0;
      pix_q      <= '0;
      grp_q      <= '0;
      used_q     <= '0;
      rg_q       <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      pixels_q   <= pixels_d;
      bias_q     <= bias_d;
      relu_q     <= relu_d;
      fetch_en_q <= fetch_en_d;
      pix_q      <= pix_d;
      grp_q      <= grp_d;
      used_q     <= used_d;
      rg_q       <= rg_d;
      acc_q      <= acc_d;
    end
  end

  sync_fifo #(
    .WIDTH (WDP),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (res_push),
    .push_data (res_val),
    .pop       (pop),
    .rd_data   (out_data),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// Directed and randomized bench for conv_acc_ctrl with an arithmetic reference model and an in-order mac emulator.
module tb_conv_acc_ctrl;

  localparam int GROUPS    = 4;
  localparam int WDP       = 9;
  localparam int WDP_OUT   = 17;
  localparam int WDP_BIAS  = 13;
  localparam int SHIFT     = 2;
  localparam int OUT_DEPTH = 4;
  localparam int PIX_W     = 16;
  localparam int GRP_W     = 2;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic                       start = 1'b0;
  logic [PIX_W-1:0]           cfg_pixels = '0;
  logic signed [WDP_BIAS-1:0] cfg_bias = '0;
  logic                       cfg_relu = 1'b0;
  logic                       busy, done, fetch_en, out_valid;
  logic [PIX_W-1:0]           fetch_pix;
  logic [GRP_W-1:0]           fetch_grp;
  logic                       mac_q_en;
  logic signed [WDP_OUT-1:0]  mac_q;
  logic                       out_ready;
  logic signed [WDP-1:0]      out_data;

  conv_acc_ctrl #(
    .INPUT_NUM(9), .GROUPS(GROUPS), .WDP(WDP), .WDP_OUT(WDP_OUT), .WDP_BIAS(WDP_BIAS),
    .WDP_ACC(22), .SHIFT(SHIFT), .OUT_DEPTH(OUT_DEPTH), .PIX_W(PIX_W)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .cfg_pixels(cfg_pixels), .cfg_bias(cfg_bias),
    .cfg_relu(cfg_relu), .busy(busy), .done(done), .fetch_en(fetch_en), .fetch_pix(fetch_pix),
    .fetch_grp(fetch_grp), .mac_q_en(mac_q_en), .mac_q(mac_q), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Shared state between the directed sequence and the negedge monitor.
  int exp_q[$];
  int mac_vals[$];
  int pend_val[$];
  int pend_due[$];
  int cur[$];
  int cyc = 0, last_due = 0;
  int fetch_cnt = 0, out_cnt = 0, done_cnt = 0, exp_fetch = 0;
  int last_out = 0, overflow_cnt = 0;
  int ready_mode = 1, lat_mode = 0;
  int plane_bias = 0;
  bit plane_relu = 1'b0;
  bit prev_stall = 1'b0;
  logic signed [WDP-1:0] prev_data = '0;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Result of one pixel from its group results: floor((sum + bias*2^SHIFT) / 2^SHIFT), ReLU, clamp.
  function automatic int model_pix(input int vals[$], input int bias, input bit relu);
    int s, r, d, hi;
    d  = 1 << SHIFT;
    hi = (1 << (WDP - 1)) - 1;
    s  = bias * d;
    foreach (vals[i]) s += vals[i];
    if (s >= 0) r = s / d;
    else        r = -((-s + d - 1) / d);
    if (relu && r < 0) r = 0;
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
    return r;
  endfunction

  // Monitor: checks fetch order, plays the mac in fetch order, drives out_ready, scores outputs.
  initial begin : mon
    int v, lat, due, e;
    mac_q_en  = 1'b0;
    mac_q     = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        exp_q.delete(); pend_val.delete(); pend_due.delete(); cur.delete();
        exp_fetch = 0; prev_stall = 1'b0; last_due = cyc;
        mac_q_en = 1'b0; mac_q = '0;
        continue;
      end
      if (dut.res_push && dut.u_fifo.full) overflow_cnt++;
      if (done) done_cnt++;
      if (fetch_en) begin
        chk("fetch_pix", fetch_pix, exp_fetch / GROUPS);
        chk("fetch_grp", fetch_grp, exp_fetch % GROUPS);
        exp_fetch++;
        fetch_cnt++;
        if (mac_vals.size() > 0) v = mac_vals.pop_front();
        else                     v = int'($urandom_range(0, 6000)) - 3000;
        lat = (lat_mode == 0) ? 3 : int'($urandom_range(1, 6));
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_val.push_back(v);
        pend_due.push_back(due);
        cur.push_back(v);
        if (cur.size() == GROUPS) begin
          exp_q.push_back(model_pix(cur, plane_bias, plane_relu));
          cur.delete();
        end
      end
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (ready_mode == 0)      out_ready = 1'b0;
      else if (ready_mode == 1) out_ready = 1'b1;
      else                      out_ready = ($urandom_range(0, 1) == 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e);
          last_out = int'(out_data);
          out_cnt++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mac_q_en = 1'b1;
        mac_q    = WDP_OUT'(pend_val.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mac_q_en = 1'b0;
        mac_q    = '0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_plane(input int pix, input int bias, input bit relu);
    plane_bias = bias; plane_relu = relu;
    fetch_cnt = 0; out_cnt = 0; done_cnt = 0; exp_fetch = 0;
    cfg_pixels = PIX_W'(pix); cfg_bias = WDP_BIAS'(bias); cfg_relu = relu;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("fetch_after_start", fetch_en, pix != 0);
  endtask

  task automatic finish_plane(input int pix, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      step();
      n++;
    end
    chk("done_seen", done, 1);
    step(); step();
    chk("fetch_count", fetch_cnt, pix * GROUPS);
    chk("out_count", out_cnt, pix);
    chk("done_count", done_cnt, 1);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_plane(input int pix, input int bias, input bit relu);
    begin_plane(pix, bias, relu);
    finish_plane(pix, 2000);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_fetch_en"}, fetch_en, 0);
    chk({tag, "_fetch_pix"}, fetch_pix, 0);
    chk({tag, "_fetch_grp"}, fetch_grp, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
  endtask

  initial begin : seq
    int pix;
    ready_mode = 1; lat_mode = 0;
    step(); step();
    check_outputs_zero("reset");
    rstn = 1'b1;
    step();

    // Directed arithmetic cases.
    mac_vals = '{100, 200, -50, 30};
    run_plane(1, 5, 1'b0);
    chk("basic_75", last_out, 75);
    mac_vals = '{1000, 1000, 1000, 1000};
    run_plane(1, 0, 1'b0);
    chk("sat_pos", last_out, 255);
    mac_vals = '{-1000, -1000, -1000, -1000};
    run_plane(1, 0, 1'b0);
    chk("sat_neg", last_out, -256);
    mac_vals = '{-100, -100, -100, -100};
    run_plane(1, 0, 1'b0);
    chk("relu_off", last_out, -100);
    mac_vals = '{-100, -100, -100, -100};
    run_plane(1, 0, 1'b1);
    chk("relu_on", last_out, 0);
    mac_vals = '{-3, 0, 0, 0};
    run_plane(1, 0, 1'b0);
    chk("floor_neg", last_out, -1);

    // Empty plane: done exactly two cycles after start, nothing issued.
    begin_plane(0, 0, 1'b0);
    chk("empty_done_t1", done, 0);
    step();
    chk("empty_done_t2", done, 1);
    chk("empty_busy_t2", busy, 1);
    step();
    chk("empty_done_t3", done, 0);
    chk("empty_busy_t3", busy, 0);
    chk("empty_fetches", fetch_cnt, 0);
    chk("empty_outputs", out_cnt, 0);

    // Credit throttling with a blocked consumer.
    ready_mode = 0; lat_mode = 0;
    begin_plane(10, 3, 1'b0);
    repeat (60) step();
    chk("bp_fetches", fetch_cnt, 16);
    chk("bp_fetch_en", fetch_en, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_busy", busy, 1);
    ready_mode = 1;
    finish_plane(10, 500);
    chk("bp_exp_left", exp_q.size(), 0);

    // Randomized planes; the first also sees an ignored start while busy.
    ready_mode = 2; lat_mode = 1;
    for (int p = 0; p < 4; p++) begin
      pix = (p == 0) ? int'($urandom_range(6, 12)) : int'($urandom_range(1, 12));
      begin_plane(pix, int'($urandom_range(0, 8190)) - 4095, ($urandom_range(0, 1) == 1));
      if (p == 0) begin
        repeat (4) step();
        cfg_pixels = PIX_W'(3); cfg_bias = '0;
        start = 1'b1;
        step();
        start = 1'b0;
      end
      finish_plane(pix, 3000);
      chk("rand_exp_left", exp_q.size(), 0);
    end

    // Reset in the middle of a plane, then a clean plane.
    ready_mode = 0; lat_mode = 0;
    begin_plane(8, 7, 1'b0);
    repeat (6) step();
    chk("pre_reset_busy", busy, 1);
    rstn = 1'b0;
    step();
    check_outputs_zero("midreset");
    rstn = 1'b1;
    step(); step();
    chk("midreset_no_done", done_cnt, 0);
    ready_mode = 1;
    mac_vals = '{100, 200, -50, 30};
    run_plane(1, 5, 1'b0);
    chk("post_reset_75", last_out, 75);

    chk("fifo_overflow", overflow_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
